// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the serial add/subtract controller.
//   state_t   : controller FSM states (IDLE, RUN, DONE)
//   SLICE_W   : bits processed per beat by the shared adder slice
//   beats_for : number of slice passes needed for a given operand width
package serial_add_sub_pkg;

  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int beats_for(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/adder_slice2.sv
// Combinational 2-bit ripple adder slice, shared across all beats.
// Ports:
//   a, b     : 2-bit operand pair for the current beat
//   cin      : carry from the previous beat
//   invert_b : 1 complements b (subtract path; the +1 arrives through cin)
//   sum      : 2-bit sum
//   c_mid    : carry out of bit 0 into bit 1 (needed for overflow on the top beat)
//   cout     : carry out of bit 1
module adder_slice2
  import serial_add_sub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  input  logic               invert_b,
  output logic [SLICE_W-1:0] sum,
  output logic               c_mid,
  output logic               cout
);

  logic [SLICE_W-1:0] b_eff;

  assign b_eff  = b ^ {SLICE_W{invert_b}};

  assign sum[0] = a[0] ^ b_eff[0] ^ cin;
  assign c_mid  = (a[0] & b_eff[0]) | (cin & (a[0] ^ b_eff[0]));

  assign sum[1] = a[1] ^ b_eff[1] ^ c_mid;
  assign cout   = (a[1] & b_eff[1]) | (c_mid & (a[1] ^ b_eff[1]));

endmodule

// File: rtl/serial_add_sub_ctrl.sv
// Multi-cycle add/subtract controller: one shared 2-bit slice, LSB pair first,
// carry held in a register between beats.
// Ports:
//   clk, reset             : rising-edge clock, asynchronous active-high reset
//   start / ready          : operand handshake (accepted in IDLE only)
//   a, b, cin, subtract    : operands and mode, captured on acceptance
//   busy                   : high while beats are being processed
//   result_valid / result_ready : result handshake (DONE state)
//   result, cout, overflow : sum/difference, final carry, signed overflow
module serial_add_sub_ctrl
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             subtract,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int BEATS  = beats_for(WIDTH);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("serial_add_sub_ctrl: WIDTH must be even and >= 2");
    end
  endgenerate

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   b_reg, b_next;
  logic               sub_reg, sub_next;
  logic               carry_reg, carry_next;
  logic [BEAT_W-1:0]  beat_reg, beat_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic               cout_reg, cout_next;
  logic               ovf_reg, ovf_next;

  logic [SLICE_W-1:0] a_pair [BEATS];
  logic [SLICE_W-1:0] b_pair [BEATS];
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_c_mid;
  logic               slice_cout;
  logic               last_beat;

  // Operand pairs laid out per beat so the slice input is a simple array select.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_pairs
      assign a_pair[gi] = a_reg[gi*SLICE_W +: SLICE_W];
      assign b_pair[gi] = b_reg[gi*SLICE_W +: SLICE_W];
    end
  endgenerate

  adder_slice2 u_slice (
    .a        (a_pair[beat_reg]),
    .b        (b_pair[beat_reg]),
    .cin      (carry_reg),
    .invert_b (sub_reg),
    .sum      (slice_sum),
    .c_mid    (slice_c_mid),
    .cout     (slice_cout)
  );

  assign last_beat = (beat_reg == BEAT_W'(BEATS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      sub_reg    <= 1'b0;
      carry_reg  <= 1'b0;
      beat_reg   <= '0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      sub_reg    <= sub_next;
      carry_reg  <= carry_next;
      beat_reg   <= beat_next;
      result_reg <= result_next;
      cout_reg   <= cout_next;
      ovf_reg    <= ovf_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    sub_next    = sub_reg;
    carry_next  = carry_reg;
    beat_next   = beat_reg;
    result_next = result_reg;
    cout_next   = cout_reg;
    ovf_next    = ovf_reg;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          a_next      = a;
          b_next      = b;
          sub_next    = subtract;
          // Two's complement subtract: ~B plus one injected as the initial carry.
          carry_next  = subtract ? 1'b1 : cin;
          beat_next   = '0;
          result_next = '0;
          cout_next   = 1'b0;
          ovf_next    = 1'b0;
          state_next  = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < BEATS; i++) begin
          if (beat_reg == BEAT_W'(i)) begin
            result_next[i*SLICE_W +: SLICE_W] = slice_sum;
          end
        end
        carry_next = slice_cout;
        beat_next  = beat_reg + 1'b1;
        if (last_beat) begin
          // On the top pair, c_mid is the carry into the result MSB.
          cout_next  = slice_cout;
          ovf_next   = slice_c_mid ^ slice_cout;
          beat_next  = '0;
          state_next = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ready        = (state_reg == IDLE);
  assign busy         = (state_reg == RUN);
  assign result_valid = (state_reg == DONE);

  // Result fields are only exposed in DONE so a partially built word never leaks out.
  assign result   = result_valid ? result_reg : '0;
  assign cout     = result_valid ? cout_reg   : 1'b0;
  assign overflow = result_valid ? ovf_reg    : 1'b0;

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
module tb_serial_add_sub_ctrl;

  localparam int W     = 8;
  localparam int BEATS = W / 2;

  logic         clk;
  logic         reset;
  logic         start;
  logic         ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         subtract;
  logic         busy;
  logic         result_valid;
  logic         result_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_add_sub_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ready        (ready),
    .a            (a),
    .b            (b),
    .cin          (cin),
    .subtract     (subtract),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .cout         (cout),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-width arithmetic, overflow from operand/result sign bits.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic msub);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb    = msub ? ~mb : mb;
    full  = {1'b0, ma} + {1'b0, bb} + (W+1)'(msub ? 1'b1 : mcin);
    e.res = full[W-1:0];
    e.co  = full[W];
    e.ov  = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
    return e;
  endfunction

  // Drive one request from a falling edge; leaves at the falling edge after acceptance.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic icin, input logic isub);
    a        = ia;
    b        = ib;
    cin      = icin;
    subtract = isub;
    start    = 1'b1;
    sb.push_back(model(ia, ib, icin, isub));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count falling edges until result_valid, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (!result_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ready, busy, result_valid, result, cout, overflow} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b busy=%b vld=%b res=%h co=%b ov=%b, expected 1 0 0 00 0 0",
               ready, busy, result_valid, result, cout, overflow);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b expected 1", ready);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] va [5] = '{8'h5A, 8'hFF, 8'h02, 8'h01, 8'h80};
    logic [W-1:0] vb [5] = '{8'h33, 8'h01, 8'h01, 8'h02, 8'h01};
    logic         vc [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic         vs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_t e;
    int   n;
    result_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (ready !== 1'b1) begin
        n_fail++;
        $display("FAIL dir%0d_ready_before: got %b expected 1", i, ready);
      end
      issue(va[i], vb[i], vc[i], vs[i]);
      wait_valid(n);
      e = sb.pop_front();
      n_checks++;
      if (n !== BEATS || result_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL dir%0d_latency: got %0d cycles vld=%b expected %0d vld=1", i, n, result_valid, BEATS);
      end
      n_checks++;
      if ({result, cout, overflow} !== {e.res, e.co, e.ov}) begin
        n_fail++;
        $display("FAIL dir%0d_result: a=%h b=%h cin=%b sub=%b got res=%h co=%b ov=%b expected res=%h co=%b ov=%b",
                 i, va[i], vb[i], vc[i], vs[i], result, cout, overflow, e.res, e.co, e.ov);
      end
      $display("dir%0d a=%h b=%h cin=%b sub=%b -> res=%h co=%b ov=%b", i, va[i], vb[i], vc[i], vs[i],
               result, cout, overflow);
      @(negedge clk);
      n_checks++;
      if (result_valid !== 1'b0 || ready !== 1'b1) begin
        n_fail++;
        $display("FAIL dir%0d_done_exit: got vld=%b rdy=%b expected vld=0 rdy=1", i, result_valid, ready);
      end
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    int   n;
    result_ready = 1'b0;
    issue(8'h9C, 8'h27, 1'b0, 1'b1);
    // Hold start high and change operands while busy: must have no effect.
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    n_checks++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_run_flags: got busy=%b rdy=%b expected busy=1 rdy=0", busy, ready);
    end
    wait_valid(n);
    e = sb.pop_front();
    n_checks++;
    if (n !== BEATS || result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d cycles vld=%b expected %0d vld=1", n, result_valid, BEATS);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({result_valid, ready, result, cout, overflow} !== {1'b1, 1'b0, e.res, e.co, e.ov}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got vld=%b rdy=%b res=%h co=%b ov=%b expected vld=1 rdy=0 res=%h co=%b ov=%b",
                 i, result_valid, ready, result, cout, overflow, e.res, e.co, e.ov);
      end
      $display("bp_hold%0d res=%h co=%b ov=%b", i, result, cout, overflow);
      if (i < 3) @(negedge clk);
    end
    start        = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (result_valid !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got vld=%b rdy=%b expected vld=0 rdy=1", result_valid, ready);
    end
    issue(8'h3C, 8'h5F, 1'b1, 1'b0);
    wait_valid(n);
    e = sb.pop_front();
    n_checks++;
    if (n !== BEATS || {result, cout, overflow} !== {e.res, e.co, e.ov}) begin
      n_fail++;
      $display("FAIL bp_after: got %0d cycles res=%h co=%b ov=%b expected %0d res=%h co=%b ov=%b",
               n, result, cout, overflow, BEATS, e.res, e.co, e.ov);
    end
    $display("bp_after res=%h co=%b ov=%b", result, cout, overflow);
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    exp_t e;
    int   n;
    result_ready = 1'b1;
    issue(8'h33, 8'h44, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_busy_before: got %b expected 1", busy);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, result_valid, ready, result, cout, overflow} !== {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ar_immediate: got busy=%b vld=%b rdy=%b res=%h co=%b ov=%b expected 0 0 1 00 0 0",
               busy, result_valid, ready, result, cout, overflow);
    end
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(8'h10, 8'h0F, 1'b0, 1'b0);
    wait_valid(n);
    e = sb.pop_front();
    n_checks++;
    if (n !== BEATS || {result, cout, overflow} !== {e.res, e.co, e.ov}) begin
      n_fail++;
      $display("FAIL ar_after: got %0d cycles res=%h co=%b ov=%b expected %0d res=%h co=%b ov=%b",
               n, result, cout, overflow, BEATS, e.res, e.co, e.ov);
    end
    $display("ar_after a=10 b=0f add -> res=%h co=%b", result, cout);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    exp_t         e;
    int           n;
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    result_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      n_checks++;
      if (ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b%0d_ready: got %b expected 1", i, ready);
      end
      issue(ra, rb, rc, rs);
      wait_valid(n);
      e = sb.pop_front();
      n_checks++;
      if (n !== BEATS || {result, cout, overflow} !== {e.res, e.co, e.ov}) begin
        n_fail++;
        $display("FAIL b2b%0d: a=%h b=%h cin=%b sub=%b got %0d cycles res=%h co=%b ov=%b expected %0d res=%h co=%b ov=%b",
                 i, ra, rb, rc, rs, n, result, cout, overflow, BEATS, e.res, e.co, e.ov);
      end
      $display("b2b%0d a=%h b=%h cin=%b sub=%b -> res=%h co=%b ov=%b", i, ra, rb, rc, rs, result, cout, overflow);
      @(negedge clk);
    end
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    a            = '0;
    b            = '0;
    cin          = 1'b0;
    subtract     = 1'b0;
    result_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_add_sub_ctrl.md
Name: serial_add_sub_ctrl

Overview:
Multi-cycle add/subtract controller for WIDTH-bit operands. A single shared 2-bit adder slice processes two bits per clock, LSB pair first, with the carry held in a register between beats. Operands arrive on a start/ready handshake; results leave on a valid/ready handshake. The block sits between operand registers and the result consumer, in place of a wide combinational adder.

Parameters:
WIDTH, 8, operand/result width in bits; must be even and >= 2 (elaboration error otherwise)
BEATS, WIDTH/2, derived localparam: slice passes per operation

Ports:
clk  input  1  rising-edge clock, the only clock
reset  input  1  asynchronous, active-high reset
start  input  1  request a new operation; accepted only when ready=1
ready  output  1  high in IDLE; start&&ready captures operands
a  input  WIDTH  operand A, captured on acceptance
b  input  WIDTH  operand B, captured on acceptance
cin  input  1  carry-in for add; ignored when subtract=1
subtract  input  1  1: A-B (two's complement), 0: A+B+cin
busy  output  1  high in RUN
result_valid  output  1  high in DONE; result fields stable
result_ready  input  1  consumer accepts result when result_valid=1
result  output  WIDTH  sum/difference
cout  output  1  final carry; for subtract, 1 means no borrow (A>=B unsigned)
overflow  output  1  signed overflow = carry into MSB XOR cout

Behaviour:
- Reset (async, any state, including mid-RUN): state=IDLE; result=0, cout=0, overflow=0, result_valid=0, busy=0; operand/carry/beat registers cleared; ready=1 once in IDLE. No partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE: ready=1. On start=1 at an edge: capture a, b, subtract; carry register = subtract ? 1 : cin; beat counter=0; result register cleared; go to RUN.
- RUN: ready=0, busy=1. Each edge, the slice adds bits [2k+1:2k] of A with (B XOR {2{subtract}}) and the carry register; the 2-bit sum is written to result[2k+1:2k]; the carry register takes the slice carry-out; k increments.
- On the final beat (k=BEATS-1): cout = slice carry-out; overflow = slice mid-carry (carry into bit 1 of the slice) XOR slice carry-out; go to DONE.
- Latency: the acceptance edge is edge 0. result_valid rises after edge BEATS (4 for WIDTH=8).
- DONE: result_valid=1; result/cout/overflow held stable. If result_ready=1 at an edge, go to IDLE and result_valid=0 next cycle. result_ready=1 already in the first DONE cycle completes in one cycle.
- start outside IDLE is ignored (not queued). Operand input changes after acceptance have no effect.
- Back-to-back: start in the cycle after DONE exits (IDLE) is accepted; minimum period is BEATS+2 cycles.
- result_ready outside DONE is ignored.
- Arithmetic is modulo 2^WIDTH. No width extension.

Decomposition:
- Package serial_add_sub_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - function beats_for(width) returning width/2;
  - slice width constant SLICE_W=2.
- One sub-module, adder_slice2: combinational 2-bit ripple adder.
  - Inputs: a[1:0], b[1:0], cin, invert_b.
  - Outputs: sum[1:0], c_mid, cout.
  - It is instantiated once and shared across all beats.

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, add, cin=0, result_ready=1 -> result_valid after edge 4; result=0x8D, cout=0, overflow=1; then ready=1.
- a=0xFF, b=0x01, add, cin=1 -> result=0x01, cout=1, overflow=0.
- Subtract with cin=1 (must be ignored):
  - a=0x02, b=0x01 -> result=0x01, cout=1, overflow=0;
  - then a=0x01, b=0x02 -> result=0xFF, cout=0, overflow=0.
- Subtract a=0x80, b=0x01 -> result=0x7F, cout=1, overflow=1.
- Backpressure: result_ready=0 for 3 DONE cycles, start=1 pulsed during RUN and DONE:
  - result/cout/overflow stable, ready=0, start ignored;
  - after result_ready=1: IDLE next cycle;
  - a new start is then accepted and produces the correct result.
- Reset asserted asynchronously during RUN beat 2 (between edges) -> immediately busy=0, result_valid=0, result=0, state IDLE; after release, a=0x10, b=0x0F add -> result=0x1F, cout=0.
